// File: rtl/int2float_pipe_if.sv
// -----------------------------------------------------------------------------
// int2float_pipe_if
// Stream bundle for the integer-to-float converter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid and its payload steady until the transfer
// happens. The consumer's ready may depend on its own state, but never on
// valid.
//
// Signals:
//   in_valid / in_ready     input-side handshake
//   in_data  [IN_W]         integer to convert
//   in_rnd                  0 truncate, 1 round-to-nearest-even
//   out_valid / out_ready   output-side handshake
//   out_sign                result sign
//   out_exp  [EXP_W]        exponent e
//   out_man  [MAN_W]        mantissa m (value = m * 2^e)
//   out_inexact             discarded bits were nonzero
//   out_ovf                 result saturated after a rounding overflow
//
// Modports:
//   slave   the converter's view
//   master  the view of the agent that feeds and drains the converter
// -----------------------------------------------------------------------------
interface int2float_pipe_if #(
    parameter int IN_W  = 11,
    parameter int MAN_W = 4,
    parameter int EXP_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_rnd;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_inexact;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_rnd, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man,
               out_inexact, out_ovf
    );

    modport master (
        output in_valid, in_data, in_rnd, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man,
               out_inexact, out_ovf
    );
endinterface

// File: rtl/int2float_pipe.sv
// -----------------------------------------------------------------------------
// int2float_pipe
// Three-stage integer-to-float converter with valid/ready flow control on
// both sides.
//   S1: capture the sample and form its magnitude.
//   S2: find the leading one, choose the exponent, extract the mantissa and
//       the guard/sticky bits.
//   S3: round (truncate or RNE), renormalise, saturate, register the result.
// Every stage register advances only when it is empty or its contents move
// on. This gives 3-cycle latency, one sample per cycle, and room for 3
// samples when the output is stalled.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bus         int2float_pipe_if.slave (input and output streams)
//   clr_sticky  synchronous clear of ovf_sticky
//   ovf_sticky  set by each output transfer that has out_ovf=1
// -----------------------------------------------------------------------------
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int EXP_W  = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    int2float_pipe_if.slave bus,
    input  logic            clr_sticky,
    output logic            ovf_sticky
);

    generate
        if (IN_W < 4 || IN_W > 32) begin : g_bad_in_w
            $error("int2float_pipe: IN_W must be in 4..32");
        end
        if (MAN_W < 2 || MAN_W > IN_W - 1) begin : g_bad_man_w
            $error("int2float_pipe: MAN_W must be in 2..IN_W-1");
        end
        if ((2 ** EXP_W) - 1 < IN_W - MAN_W) begin : g_bad_exp_w
            $error("int2float_pipe: EXP_W too small for IN_W-MAN_W");
        end
    endgenerate

    // ---------------- stage registers ----------------
    logic             s1_full, s1_sign, s1_rnd;
    logic [IN_W-1:0]  s1_mag;

    logic             s2_full, s2_sign, s2_rnd, s2_guard, s2_sticky;
    logic [EXP_W-1:0] s2_exp;
    logic [MAN_W-1:0] s2_man;

    logic             s3_full, s3_sign, s3_inexact, s3_ovf;
    logic [EXP_W-1:0] s3_exp;
    logic [MAN_W-1:0] s3_man;

    // ---------------- flow control ----------------
    logic out_xfer, s3_can_load, s2_adv, s2_can_load, s1_adv, in_xfer;

    assign out_xfer    = s3_full & bus.out_ready;
    assign s3_can_load = ~s3_full | bus.out_ready;
    assign s2_adv      = s2_full & s3_can_load;
    assign s2_can_load = ~s2_full | s2_adv;
    assign s1_adv      = s1_full & s2_can_load;

    // Both handshake outputs are forced low while reset is held.
    assign bus.in_ready  = rst_n & (~s1_full | s1_adv);
    assign bus.out_valid = rst_n & s3_full;
    assign in_xfer       = bus.in_valid & bus.in_ready;

    // ---------------- S1: magnitude ----------------
    logic            in_neg;
    logic [IN_W-1:0] in_mag;

    // The most negative input negates to 2^(IN_W-1). That value still fits
    // when read as unsigned.
    assign in_neg = SIGNED & bus.in_data[IN_W-1];
    assign in_mag = in_neg ? (~bus.in_data + IN_W'(1)) : bus.in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_sign <= 1'b0;
            s1_rnd  <= 1'b0;
            s1_mag  <= '0;
        end else if (in_xfer) begin
            s1_full <= 1'b1;
            s1_sign <= in_neg;
            s1_rnd  <= bus.in_rnd;
            s1_mag  <= in_mag;
        end else if (s1_adv) begin
            s1_full <= 1'b0;
        end
    end

    // ---------------- S2: normalise ----------------
    int               lead;
    int               sh;
    logic [IN_W-1:0]  low_mask;
    logic [IN_W-1:0]  guard_mask;
    logic [MAN_W-1:0] man_d;
    logic             guard_d, sticky_d;

    always_comb begin
        lead = 0;
        for (int i = 0; i < IN_W; i++) begin
            if (s1_mag[i]) lead = i;
        end
        // A value that already fits in MAN_W bits keeps e=0 and is exact.
        sh         = (lead > MAN_W - 1) ? lead - (MAN_W - 1) : 0;
        man_d      = MAN_W'(s1_mag >> sh);
        low_mask   = ~({IN_W{1'b1}} << sh);
        guard_mask = (sh == 0) ? '0 : (IN_W'(1) << (sh - 1));
        guard_d    = |(s1_mag & guard_mask);
        sticky_d   = |(s1_mag & low_mask & ~guard_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_full   <= 1'b0;
            s2_sign   <= 1'b0;
            s2_rnd    <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s2_man    <= '0;
        end else if (s1_adv) begin
            s2_full   <= 1'b1;
            s2_sign   <= s1_sign;
            s2_rnd    <= s1_rnd;
            s2_guard  <= guard_d;
            s2_sticky <= sticky_d;
            s2_exp    <= EXP_W'(sh);
            s2_man    <= man_d;
        end else if (s2_adv) begin
            s2_full <= 1'b0;
        end
    end

    // ---------------- S3: round / saturate ----------------
    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic [MAN_W:0]   man_norm;
    logic [EXP_W:0]   exp_sum;
    logic [MAN_W-1:0] man_r;
    logic [EXP_W-1:0] exp_r;
    logic             ovf_r, inex_r;

    always_comb begin
        round_up = s2_rnd & s2_guard & (s2_sticky | s2_man[0]);
        man_sum  = {1'b0, s2_man} + {{MAN_W{1'b0}}, round_up};
        man_norm = man_sum;
        exp_sum  = {1'b0, s2_exp};
        // A carry out of the mantissa can only come from all-ones + 1, so
        // halving gives exactly 2^(MAN_W-1).
        if (man_sum[MAN_W]) begin
            man_norm = man_sum >> 1;
            exp_sum  = {1'b0, s2_exp} + {{EXP_W{1'b0}}, 1'b1};
        end
        ovf_r  = exp_sum[EXP_W];
        inex_r = s2_guard | s2_sticky;
        man_r  = man_norm[MAN_W-1:0];
        exp_r  = exp_sum[EXP_W-1:0];
        if (ovf_r) begin
            man_r  = '1;
            exp_r  = '1;
            inex_r = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_full    <= 1'b0;
            s3_sign    <= 1'b0;
            s3_exp     <= '0;
            s3_man     <= '0;
            s3_inexact <= 1'b0;
            s3_ovf     <= 1'b0;
        end else if (s2_adv) begin
            s3_full    <= 1'b1;
            s3_sign    <= s2_sign;
            s3_exp     <= exp_r;
            s3_man     <= man_r;
            s3_inexact <= inex_r;
            s3_ovf     <= ovf_r;
        end else if (out_xfer) begin
            s3_full <= 1'b0;
        end
    end

    assign bus.out_sign    = s3_sign;
    assign bus.out_exp     = s3_exp;
    assign bus.out_man     = s3_man;
    assign bus.out_inexact = s3_inexact;
    assign bus.out_ovf     = s3_ovf;

    // Set has priority over clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_xfer && s3_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int2float_pipe.sv
// -----------------------------------------------------------------------------
// tb_int2float_pipe
// Self-checking bench for int2float_pipe.
//   dut   : default parameters, unsigned input
//   dut_s : SIGNED=1
// Driven samples push their expected {sign,exp,man,inexact,ovf} onto a queue.
// A monitor pops and compares that queue on every output transfer.
// -----------------------------------------------------------------------------
module tb_int2float_pipe;
    localparam int IN_W  = 11;
    localparam int MAN_W = 4;
    localparam int EXP_W = 3;

    typedef struct {
        logic [10:0] d;
        logic        r;
        logic [9:0]  res;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_sticky = 1'b0;
    logic clr_sticky_s = 1'b0;
    logic ovf_sticky, ovf_sticky_s;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int2float_pipe_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) bus ();
    int2float_pipe_if #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W)) bus_s ();

    int2float_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W), .SIGNED(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    int2float_pipe #(.IN_W(IN_W), .MAN_W(MAN_W), .EXP_W(EXP_W), .SIGNED(1'b1)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_s),
        .clr_sticky (clr_sticky_s),
        .ovf_sticky (ovf_sticky_s)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];
    logic [9:0] exp_s_q[$];
    int         out_cyc_q[$];
    int         checks = 0;
    int         errors = 0;
    int         last_acc = 0;
    bit         bp_en = 1'b0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    function automatic logic [9:0] pk(input logic s, input int e, input int m,
                                      input logic inx, input logic ov);
        return {s, e[2:0], m[3:0], inx, ov};
    endfunction

    // Reference model: shift right one bit at a time, collecting guard/sticky.
    function automatic logic [9:0] model(input logic [10:0] d, input logic r, input bit sgn);
        logic        s, g, st, up, inx, ov;
        logic [11:0] m;
        int          e;
        s  = sgn & d[10];
        m  = s ? (12'd2048 - {1'b0, d}) : {1'b0, d};
        e  = 0;
        g  = 1'b0;
        st = 1'b0;
        while (m >= 12'd16) begin
            st = st | g;
            g  = m[0];
            m  = m >> 1;
            e++;
        end
        inx = g | st;
        up  = r & g & (st | m[0]);
        m   = m + 12'(up);
        if (m == 12'd16) begin
            m = 12'd8;
            e++;
        end
        ov = (e > 7);
        if (ov) begin
            m   = 12'd15;
            e   = 7;
            inx = 1'b1;
        end
        return pk(s, e, int'(m), inx, ov);
    endfunction

    // ---------------- monitors ----------------
    initial begin : monitor
        logic [9:0] got;
        logic [9:0] prev_val;
        bit         prev_stall;
        prev_stall = 1'b0;
        prev_val   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                got = {bus.out_sign, bus.out_exp, bus.out_man, bus.out_inexact, bus.out_ovf};
                if (prev_stall && bus.out_valid) check("out_hold", 32'(got), 32'(prev_val));
                if (bus.out_valid && bus.out_ready) begin
                    out_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected got=%0h want=none", got);
                    end else begin
                        check("out_result", 32'(got), 32'(exp_q.pop_front()));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_val   = got;
            end
        end
    end

    initial begin : monitor_s
        logic [9:0] got;
        forever begin
            @(negedge clk);
            if (rst_n && bus_s.out_valid && bus_s.out_ready) begin
                got = {bus_s.out_sign, bus_s.out_exp, bus_s.out_man,
                       bus_s.out_inexact, bus_s.out_ovf};
                if (exp_s_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL signed_unexpected got=%0h want=none", got);
                end else begin
                    check("signed_result", 32'(got), 32'(exp_s_q.pop_front()));
                end
            end
        end
    end

    // Random backpressure on the unsigned output while bp_en is set.
    initial begin : backpressure
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1. Returns at posedge+1 of the cycle after acceptance.
    task automatic send(input bit sel, input logic [10:0] d, input logic r, input logic [9:0] res);
        int  waited;
        bit  rdy;
        waited = 0;
        if (sel) begin
            bus_s.in_valid = 1'b1; bus_s.in_data = d; bus_s.in_rnd = r;
        end else begin
            bus.in_valid = 1'b1; bus.in_data = d; bus.in_rnd = r;
        end
        @(negedge clk);
        rdy = sel ? bus_s.in_ready : bus.in_ready;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            waited++;
            rdy = sel ? bus_s.in_ready : bus.in_ready;
        end
        if (!rdy) begin
            check("send_timeout", 32'(waited), 0);
        end else begin
            last_acc = cyc;
            if (sel) exp_s_q.push_back(res);
            else     exp_q.push_back(res);
        end
        align();
        if (sel) bus_s.in_valid = 1'b0;
        else     bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || exp_s_q.size() != 0) && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("drain_left", 32'(exp_q.size() + exp_s_q.size()), 0);
        align();
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[18];
    vec_t tbl_s[5];

    initial begin : main
        int n0;
        int accepts;
        int b;
        logic [10:0] d;
        logic        r;

        tbl[0]  = '{11'd0,    1'b0, pk(0, 0, 0,  0, 0)};
        tbl[1]  = '{11'd11,   1'b0, pk(0, 0, 11, 0, 0)};
        tbl[2]  = '{11'd200,  1'b0, pk(0, 4, 12, 1, 0)};
        tbl[3]  = '{11'd200,  1'b1, pk(0, 4, 12, 1, 0)};
        tbl[4]  = '{11'd216,  1'b1, pk(0, 4, 14, 1, 0)};
        tbl[5]  = '{11'd216,  1'b0, pk(0, 4, 13, 1, 0)};
        tbl[6]  = '{11'd2047, 1'b0, pk(0, 7, 15, 1, 0)};
        tbl[7]  = '{11'd2047, 1'b1, pk(0, 7, 15, 1, 1)};
        tbl[8]  = '{11'd15,   1'b1, pk(0, 0, 15, 0, 0)};
        tbl[9]  = '{11'd16,   1'b0, pk(0, 1, 8,  0, 0)};
        tbl[10] = '{11'd17,   1'b1, pk(0, 1, 8,  1, 0)};
        tbl[11] = '{11'd19,   1'b1, pk(0, 1, 10, 1, 0)};
        tbl[12] = '{11'd31,   1'b1, pk(0, 2, 8,  1, 0)};
        tbl[13] = '{11'd1023, 1'b1, pk(0, 7, 8,  1, 0)};
        tbl[14] = '{11'd1023, 1'b0, pk(0, 6, 15, 1, 0)};
        tbl[15] = '{11'd1920, 1'b1, pk(0, 7, 15, 0, 0)};
        tbl[16] = '{11'd1984, 1'b1, pk(0, 7, 15, 1, 1)};
        tbl[17] = '{11'd1,    1'b1, pk(0, 0, 1,  0, 0)};

        tbl_s[0] = '{11'h400, 1'b0, pk(1, 7, 8,  0, 0)};
        tbl_s[1] = '{11'h7FF, 1'b0, pk(1, 0, 1,  0, 0)};
        tbl_s[2] = '{11'h738, 1'b1, pk(1, 4, 12, 1, 0)};
        tbl_s[3] = '{11'h728, 1'b1, pk(1, 4, 14, 1, 0)};
        tbl_s[4] = '{11'h001, 1'b0, pk(0, 0, 1,  0, 0)};

        bus.in_valid   = 1'b0; bus.in_data   = '0; bus.in_rnd   = 1'b0; bus.out_ready   = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_rnd = 1'b0; bus_s.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_outputs", 32'({bus.out_sign, bus.out_exp, bus.out_man,
                                  bus.out_inexact, bus.out_ovf}), 0);
        check("rst_sticky", 32'(ovf_sticky), 0);
        align();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 1);
        align();

        // 0, 11, 200 back to back: results in cycles N+3..N+5
        out_cyc_q.delete();
        send(0, tbl[0].d, tbl[0].r, tbl[0].res);
        n0 = last_acc;
        send(0, tbl[1].d, tbl[1].r, tbl[1].res);
        send(0, tbl[2].d, tbl[2].r, tbl[2].res);
        drain();
        check("lat_count", 32'(out_cyc_q.size()), 3);
        if (out_cyc_q.size() == 3) begin
            check("lat_first", 32'(out_cyc_q[0]), 32'(n0 + 3));
            check("lat_second", 32'(out_cyc_q[1]), 32'(n0 + 4));
            check("lat_third", 32'(out_cyc_q[2]), 32'(n0 + 5));
        end
        check("sticky_still_0", 32'(ovf_sticky), 0);

        // Full table, streamed back to back
        for (int i = 0; i < 18; i++) send(0, tbl[i].d, tbl[i].r, tbl[i].res);
        drain();
        check("sticky_set", 32'(ovf_sticky), 1);
        clr_sticky = 1'b1;
        align();
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 32'(ovf_sticky), 0);
        align();

        // Clear and set in the same cycle: set wins
        bus.out_ready = 1'b0;
        send(0, 11'd2047, 1'b1, pk(0, 7, 15, 1, 1));
        b = 0;
        @(negedge clk);
        while (!bus.out_valid && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("ovf_at_output", 32'(bus.out_valid), 1);
        align();
        bus.out_ready = 1'b1;
        clr_sticky = 1'b1;
        align();
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_set_wins", 32'(ovf_sticky), 1);
        align();
        clr_sticky = 1'b1;
        align();
        clr_sticky = 1'b0;

        // Output stalled for 6 cycles with input offered every cycle
        bus.out_ready = 1'b0;
        accepts = 0;
        for (int k = 0; k < 6; k++) begin
            d = 11'(100 + 37 * accepts);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_rnd   = 1'b1;
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(d, 1'b1, 1'b0));
                accepts++;
            end
            align();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_accepts", 32'(accepts), 3);
        check("stall_in_ready", 32'(bus.in_ready), 0);
        align();
        out_cyc_q.delete();
        bus.out_ready = 1'b1;
        drain();
        check("stall_out_count", 32'(out_cyc_q.size()), 3);
        if (out_cyc_q.size() == 3) begin
            check("stall_no_gap_1", 32'(out_cyc_q[1]), 32'(out_cyc_q[0] + 1));
            check("stall_no_gap_2", 32'(out_cyc_q[2]), 32'(out_cyc_q[1] + 1));
        end

        // Reset with two samples in flight
        send(0, 11'd300, 1'b0, model(11'd300, 1'b0, 1'b0));
        send(0, 11'd301, 1'b1, model(11'd301, 1'b1, 1'b0));
        rst_n = 1'b0;
        align();
        rst_n = 1'b1;
        exp_q.delete();
        out_cyc_q.delete();
        @(negedge clk);
        check("rst2_in_ready", 32'(bus.in_ready), 1);
        align();
        repeat (5) align();
        check("rst2_flushed", 32'(out_cyc_q.size()), 0);
        send(0, 11'd500, 1'b1, model(11'd500, 1'b1, 1'b0));
        n0 = last_acc;
        drain();
        check("rst2_out_count", 32'(out_cyc_q.size()), 1);
        if (out_cyc_q.size() == 1) check("rst2_latency", 32'(out_cyc_q[0]), 32'(n0 + 3));

        // Random stimulus under random backpressure
        bp_en = 1'b1;
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) align();
            d = 11'($urandom_range(0, 2047));
            r = 1'($urandom_range(0, 1));
            send(0, d, r, model(d, r, 1'b0));
        end
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;

        // Signed instance
        for (int i = 0; i < 5; i++) send(1, tbl_s[i].d, tbl_s[i].r, tbl_s[i].res);
        for (int k = 0; k < 40; k++) begin
            d = 11'($urandom_range(0, 2047));
            r = 1'($urandom_range(0, 1));
            send(1, d, r, model(d, r, 1'b1));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int2float_pipe.md
INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

Interface
REQ-001 Parameter IN_W, default 11: integer input width; legal range 4..32.
REQ-002 Parameter MAN_W, default 4: mantissa width, including the explicit leading one; legal range 2..IN_W-1.
REQ-003 Parameter EXP_W, default 3: exponent width; elaboration fails unless 2^EXP_W-1 >= IN_W-MAN_W.
REQ-004 Parameter SIGNED, default 0: 1 means the input is two's complement and the sign bit is extracted.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  input sample offered.
REQ-008 in_ready  output  1  block accepts the sample this cycle.
REQ-009 in_data  input  IN_W  integer to convert.
REQ-010 in_rnd  input  1  per-sample rounding mode: 0 truncate, 1 round-to-nearest-even (RNE).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sign  output  1  sign of the result; always 0 when SIGNED=0.
REQ-014 out_exp  output  EXP_W  exponent e.
REQ-015 out_man  output  MAN_W  mantissa m; the result value is m*2^e.
REQ-016 out_inexact  output  1  discarded bits were nonzero.
REQ-017 out_ovf  output  1  rounding overflowed the exponent and the result was saturated.
REQ-018 ovf_sticky  output  1  OR of out_ovf over all accepted results since reset or clear.
REQ-019 clr_sticky  input  1  synchronous clear of ovf_sticky.

Function
REQ-020 Handshakes: a transfer occurs when valid and ready are both 1 in the same cycle; in_data and in_rnd are captured together on that transfer.
REQ-021 Pipeline: 3 stages.
- S1: capture the input and form the magnitude |x| (IN_W bits; for SIGNED=1 the most negative input maps to 2^(IN_W-1)).
- S2: leading-one position p, then e=max(0,p-(MAN_W-1)), m=|x|>>e, plus guard, sticky and the LSB of m.
- S3: rounding, renormalisation, saturation and output register.
REQ-022 Latency: an input accepted in cycle N appears with out_valid=1 in cycle N+3 when no stalls occur; throughput is 1 sample per cycle.
REQ-023 Backpressure: each stage advances only when its own register is empty or the next stage advances; in_ready = NOT S1-full OR S1 advances.
- Capacity is 3 samples.
- No sample is lost, duplicated or reordered under any out_ready pattern.
REQ-024 Output stability: outputs hold steady while out_valid=1 and out_ready=0.
REQ-025 Zero input: result is m=0, e=0, sign=0, inexact=0, ovf=0.
REQ-026 Inputs with p <= MAN_W-1: result is e=0, m=|x|, inexact=0; this result is exact and denormal-style.
REQ-027 Truncate mode: m=|x|>>e; inexact=1 if any of the shifted-out bits is 1.
REQ-028 RNE mode, rounding decision: round up when the guard bit is 1 and either the sticky bit is 1 or the LSB of m is 1; inexact is the same as in truncate mode.
REQ-029 RNE mode, renormalisation: if rounding gives m=2^MAN_W, then m=2^(MAN_W-1) and e=e+1.
REQ-030 Saturation: if e after REQ-029 exceeds 2^EXP_W-1, the result is m=2^MAN_W-1, e=2^EXP_W-1, out_ovf=1, inexact=1.
REQ-031 Sign: out_sign is the input MSB when SIGNED=1; magnitude and rounding never depend on sign.
REQ-032 ovf_sticky update: set on an output transfer with out_ovf=1; clr_sticky=1 clears it.
- If clear and set happen in the same cycle, set wins.

Reset
REQ-033 rst_n=0 at a rising edge empties all stages, mid-operation included, and discards in-flight samples.
REQ-034 While rst_n=0, out_valid=0 and in_ready=0.
REQ-035 Reset values: out_sign, out_exp, out_man, out_inexact, out_ovf and ovf_sticky are all 0.
REQ-036 in_ready=1 in the first cycle after rst_n returns to 1.

Verification (default parameters unless stated)
REQ-037 in=0, 11, 200 in consecutive cycles, rnd=0, out_ready=1 -> in cycles N+3..N+5: (m,e)=(0,0),(11,0),(12,4); inexact=0,0,1.
REQ-038 RNE ties -> in=200 gives (12,4) (even, kept); in=216 gives (14,4) (odd, rounded up); inexact=1 for both.
REQ-039 in=2047 -> rnd=0 gives (15,7), ovf=0; rnd=1 gives (15,7), ovf=1, inexact=1, and ovf_sticky=1 until clr_sticky.
REQ-040 out_ready=0 for 6 cycles with in_valid=1 continuously -> in_ready drops after exactly 3 accepts; after out_ready=1, results emerge in order with no gaps or duplicates.
REQ-041 SIGNED=1, in=-1024 (0x400) -> sign=1, (m,e)=(8,7); in=-1 gives sign=1, (1,0).
REQ-042 rst_n=0 for 1 cycle with 2 samples in flight -> no out_valid afterwards for those samples; the next accepted input emerges at exactly +3 cycles.
